// File: rtl/cpu_pkg.sv
// Shared types and opcode map for the 4-bit CPU front end.
package cpu_pkg;

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        TARGET = 3'd3,
        EXEC   = 3'd4
    } state_t;

    localparam logic [3:0] OP_JC  = 4'h0;
    localparam logic [3:0] OP_JNC = 4'h1;
    localparam logic [3:0] OP_JZ  = 4'h2;
    localparam logic [3:0] OP_JNZ = 4'h3;
    localparam logic [3:0] OP_J   = 4'h4;

    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JC) || (op == OP_JNC) || (op == OP_JZ) ||
               (op == OP_JNZ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/branch_unit.sv
// Jump condition resolution against the ALU flags; non-jump opcodes never take.
module branch_unit
    import cpu_pkg::*;
(
    input  logic [3:0] instr,
    input  logic       carry,
    input  logic       zero,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (instr)
            OP_JC:   take = carry;
            OP_JNC:  take = ~carry;
            OP_JZ:   take = zero;
            OP_JNZ:  take = ~zero;
            OP_J:    take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end sequencer: owns the program counter and sequences fetch/decode/target/exec.
//  state  | meaning
//  BOOT   | first cycle out of reset, all strobes low
//  FETCH  | Fetch register captures ROM[pc], pc advances
//  DECODE | opcode inspected, jumps go fetch their second byte
//  TARGET | second jump byte latched into tgt_lo, pc advances
//  EXEC   | execute strobe; taken jumps load {operand, tgt_lo}
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W       = 12,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        program_byte,
    input  logic [3:0]        instr,
    input  logic [3:0]        operand,
    input  logic              carry,
    input  logic              zero,
    input  logic              stall,
    output logic [ADDR_W-1:0] address,
    output logic              phase,
    output logic              exec_en,
    output logic              branch_taken
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_tgt_lo;
    logic              w_take;
    logic [ADDR_W-1:0] w_target;

    branch_unit u_branch (
        .instr (instr),
        .carry (carry),
        .zero  (zero),
        .take  (w_take)
    );

    assign w_target = ADDR_W'({operand, r_tgt_lo});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= BOOT;
            r_pc     <= RESET_VECTOR;
            r_tgt_lo <= '0;
        end else if (!stall) begin
            case (r_state)
                BOOT: r_state <= FETCH;
                FETCH: begin
                    r_pc    <= r_pc + ADDR_W'(1);
                    r_state <= DECODE;
                end
                DECODE: r_state <= is_jump(instr) ? TARGET : EXEC;
                TARGET: begin
                    r_tgt_lo <= program_byte;
                    r_pc     <= r_pc + ADDR_W'(1);
                    r_state  <= EXEC;
                end
                EXEC: begin
                    if (w_take) r_pc <= w_target;
                    r_state <= FETCH;
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    // Strobes decode straight from state so a stall or reset kills them in the same cycle.
    assign address      = r_pc;
    assign phase        = (r_state == FETCH) && !stall;
    assign exec_en      = (r_state == EXEC) && !stall;
    assign branch_taken = (r_state == EXEC) && !stall && w_take;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus random program execution against an instruction-level reference model.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  program_byte;
    logic [3:0]  instr;
    logic [3:0]  operand;
    logic        carry;
    logic        zero;
    logic        stall;
    logic [11:0] address;
    logic        phase;
    logic        exec_en;
    logic        branch_taken;

    logic [7:0]  rom [4096];
    logic [7:0]  fetch_q;
    logic [11:0] exp_pc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .program_byte (program_byte),
        .instr        (instr),
        .operand      (operand),
        .carry        (carry),
        .zero         (zero),
        .stall        (stall),
        .address      (address),
        .phase        (phase),
        .exec_en      (exec_en),
        .branch_taken (branch_taken)
    );

    // Environment: ROM and the Fetch register enabled by phase.
    assign program_byte = rom[address];
    always @(posedge clk or negedge reset) begin
        if (!reset) fetch_q <= 8'h00;
        else if (phase) fetch_q <= program_byte;
    end
    assign instr   = fetch_q[7:4];
    assign operand = fetch_q[3:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic rnd_flags();
        carry = 1'($urandom);
        zero  = 1'($urandom);
    endtask

    // Reference: one instruction's visible behaviour from the ISA rules.
    function automatic bit ref_taken(input logic [3:0] op, input logic c, input logic z);
        case (op)
            4'h0: return c == 1'b1;
            4'h1: return c == 1'b0;
            4'h2: return z == 1'b1;
            4'h3: return z == 1'b0;
            4'h4: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Entered positioned in a FETCH cycle; leaves positioned in the next FETCH cycle.
    task automatic run_instr(input logic c, input logic z, input int n_stall, input bit rst_in_exec);
        logic [11:0] pc0, pc1, nxt;
        logic [7:0]  op_b, b2;
        bit          jmp, tk;
        pc0  = exp_pc;
        pc1  = pc0 + 12'd1;
        op_b = rom[pc0];
        b2   = rom[pc1];
        jmp  = (op_b[7:4] <= 4'h4);
        #1;
        chk("fetch_phase", 32'(phase), 32'd1);
        chk("fetch_addr", 32'(address), 32'(pc0));
        cyc(); rnd_flags(); #1;
        chk("decode_phase", 32'(phase), 32'd0);
        chk("decode_exec", 32'(exec_en), 32'd0);
        chk("decode_addr", 32'(address), 32'(pc1));
        if (jmp) begin
            cyc(); rnd_flags(); #1;
            chk("target_addr", 32'(address), 32'(pc1));
            chk("target_exec", 32'(exec_en), 32'd0);
            for (int i = 0; i < n_stall; i++) begin
                stall = 1'b1; #1;
                chk("stall_tgt_phase", 32'(phase), 32'd0);
                chk("stall_tgt_addr", 32'(address), 32'(pc1));
                cyc(); rnd_flags(); #1;
                chk("stall_tgt_hold", 32'(address), 32'(pc1));
                chk("stall_tgt_exec", 32'(exec_en), 32'd0);
            end
            stall = 1'b0;
        end
        cyc();
        carry = c; zero = z; #1;
        tk = jmp && ref_taken(op_b[7:4], c, z);
        if (n_stall > 0) begin
            stall = 1'b1; #1;
            chk("stall_exec_en", 32'(exec_en), 32'd0);
            chk("stall_exec_br", 32'(branch_taken), 32'd0);
            cyc(); #1;
            stall = 1'b0; #1;
        end
        chk("exec_en", 32'(exec_en), 32'd1);
        chk("exec_phase", 32'(phase), 32'd0);
        chk("branch_taken", 32'(branch_taken), 32'(tk));
        nxt = tk ? {op_b[3:0], b2} : (jmp ? pc0 + 12'd2 : pc0 + 12'd1);
        if (rst_in_exec) begin
            reset = 1'b0; #1;
            chk("rst_exec_addr", 32'(address), 32'h000);
            chk("rst_exec_en", 32'(exec_en), 32'd0);
            chk("rst_exec_br", 32'(branch_taken), 32'd0);
            exp_pc = 12'h000;
        end else begin
            cyc(); rnd_flags();
            exp_pc = nxt;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h70;
        rom[12'h000] = 8'h5A; rom[12'h001] = 8'h63;
        rom[12'h002] = 8'h2A; rom[12'h003] = 8'hBC;
        rom[12'hABC] = 8'h4F; rom[12'hABD] = 8'hFF;
        rom[12'hFFF] = 8'h70;
        reset = 1'b0; stall = 1'b0; carry = 1'b0; zero = 1'b0;
        repeat (3) cyc();
        chk("rst_addr", 32'(address), 32'h000);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_exec", 32'(exec_en), 32'd0);
        reset = 1'b1; #1;
        chk("boot_phase", 32'(phase), 32'd0);
        chk("boot_addr", 32'(address), 32'h000);
        cyc();
        exp_pc = 12'h000;

        run_instr(1'b0, 1'b0, 0, 1'b0);          // 5A straight line
        run_instr(1'b1, 1'b1, 0, 1'b0);          // 63 straight line
        run_instr(1'b0, 1'b1, 0, 1'b0);          // JZ taken -> ABC
        chk("jz_target", 32'(exp_pc), 32'hABC);
        run_instr(1'b0, 1'b0, 0, 1'b0);          // J -> FFF
        run_instr(1'b1, 1'b0, 0, 1'b0);          // non-jump at FFF wraps
        chk("wrap_pc", 32'(exp_pc), 32'h000);

        rom[12'h002] = 8'h0A;
        rom[12'h004] = 8'h4F; rom[12'h005] = 8'hFE;
        rom[12'hFFE] = 8'h31;
        run_instr(1'b1, 1'b0, 0, 1'b0);
        run_instr(1'b1, 1'b0, 0, 1'b0);
        run_instr(1'b0, 1'b1, 3, 1'b0);          // JC not taken, stalled in TARGET
        chk("jc_nt_pc", 32'(exp_pc), 32'h004);
        run_instr(1'b0, 1'b0, 0, 1'b0);          // J -> FFE
        run_instr(1'b1, 1'b1, 0, 1'b0);          // JNZ not taken, TARGET wraps
        chk("jnz_wrap_pc", 32'(exp_pc), 32'h000);

        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        for (int n = 0; n < 60; n++)
            run_instr(1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'b0);

        run_instr(1'($urandom), 1'($urandom), 0, 1'b1);
        cyc();
        reset = 1'b1; #1;
        chk("reboot_phase", 32'(phase), 32'd0);
        cyc();
        run_instr(1'($urandom), 1'($urandom), 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
